nibble_sequencer: RTL and testbench



---
 rtl/nibble_sequencer.sv | 174 +++++++++++++++++
 tb/tb_nibble_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_sequencer.sv
// Fetch/issue controller for nibble-packed 64-bit instruction words: fetches over
// req/ack, issues one opcode per handshake, tracks tail nibbles. Option: NIBBLE_SEQUENCER_PREFETCH_EN.
module nibble_sequencer #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic [63:0]       fetch_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [3:0]        op,
  input  logic [2:0]        op_len,
  output logic [4:0]        op_tail_off,
  output logic [63:0]       ir,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic              tail_err
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_ISSUE   = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        p_q, p_d;
  logic [4:0]        t_q, t_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [ADDR_W-1:0] addr_d;
  logic [63:0]       ir_d;
  logic              req_d;
  logic              err_d;
  logic              ack_done;
  logic              hs;
  logic [5:0]        s;

`ifdef NIBBLE_SEQUENCER_PREFETCH_EN
  logic [63:0] buf_q, buf_d;
  logic        buf_valid_q, buf_valid_d;
`endif

  assign ack_done    = fetch_req && fetch_ack;
  assign op_valid    = (state_q == S_ISSUE) && !flush;
  assign hs          = op_valid && op_ready;
  // Slot p occupies ir[63-4p -: 4]; 63-4p == {~p, 2'b11}.
  assign op          = ir[{~p_q, 2'b11} -: 4];
  assign op_tail_off = t_q;
  assign s           = {2'b00, p_q} + 6'd1 + {1'b0, t_q} + {3'b000, op_len};

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    t_d     = t_q;
    pend_d  = pend_q;
    addr_d  = fetch_addr;
    ir_d    = ir;
    err_d   = 1'b0;
`ifdef NIBBLE_SEQUENCER_PREFETCH_EN
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
`endif

    if (flush) begin
`ifdef NIBBLE_SEQUENCER_PREFETCH_EN
      buf_valid_d = 1'b0;
`endif
      if (fetch_req && !fetch_ack) begin
        // An outstanding request cannot be withdrawn; remember the target.
        state_d = S_DISCARD;
        pend_d  = flush_addr;
      end else begin
        state_d = S_FETCH;
        addr_d  = flush_addr;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (ack_done) begin
            ir_d    = fetch_data;
            p_d     = '0;
            t_d     = '0;
            addr_d  = fetch_addr + ADDR_W'(1);
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef NIBBLE_SEQUENCER_PREFETCH_EN
          if (ack_done) begin
            buf_d       = fetch_data;
            buf_valid_d = 1'b1;
            addr_d      = fetch_addr + ADDR_W'(1);
          end
`endif
          if (hs) begin
            if (s < 6'd16) begin
              p_d = p_q + 4'd1;
              t_d = t_q + {2'b00, op_len};
            end else begin
              err_d   = (s > 6'd16);
              state_d = S_FETCH;
`ifdef NIBBLE_SEQUENCER_PREFETCH_EN
              // Swap in the next word on the same edge to avoid a bubble.
              if (buf_valid_q || ack_done) begin
                ir_d        = buf_valid_q ? buf_q : fetch_data;
                p_d         = '0;
                t_d         = '0;
                buf_valid_d = 1'b0;
                state_d     = S_ISSUE;
              end
`endif
            end
          end
        end
        S_DISCARD: begin
          if (ack_done) begin
            addr_d  = pend_q;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end

    // A completed handshake always leaves one cycle with fetch_req low.
`ifdef NIBBLE_SEQUENCER_PREFETCH_EN
    req_d = !ack_done && ((state_d == S_FETCH) || (state_d == S_DISCARD) ||
                          ((state_d == S_ISSUE) && !buf_valid_d));
`else
    req_d = !ack_done && ((state_d == S_FETCH) || (state_d == S_DISCARD));
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_FETCH;
      fetch_req  <= 1'b0;
      fetch_addr <= RESET_ADDR;
      ir         <= '0;
      p_q        <= '0;
      t_q        <= '0;
      pend_q     <= RESET_ADDR;
      tail_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_req  <= req_d;
      fetch_addr <= addr_d;
      ir         <= ir_d;
      p_q        <= p_d;
      t_q        <= t_d;
      pend_q     <= pend_d;
      tail_err   <= err_d;
    end
  end

`ifdef NIBBLE_SEQUENCER_PREFETCH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_sequencer.sv
// Scoreboard bench for nibble_sequencer: stimulus pushes expected ops, a monitor
// pops and compares on every op handshake; control behaviour is checked inline.
module tb_nibble_sequencer;
  localparam int ADDR_W = 16;
  localparam logic [63:0] W1 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] W2 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] W3 = 64'h0F1E_2D3C_4B5A_6978;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack = 1'b0;
  logic [63:0]       fetch_data = '0;
  logic              op_valid;
  logic              op_ready = 1'b0;
  logic [3:0]        op;
  logic [2:0]        op_len = '0;
  logic [4:0]        op_tail_off;
  logic [63:0]       ir;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] flush_addr = '0;
  logic              tail_err;

  nibble_sequencer #(.ADDR_W(ADDR_W), .RESET_ADDR('0)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .op_valid(op_valid), .op_ready(op_ready), .op(op), .op_len(op_len),
    .op_tail_off(op_tail_off), .ir(ir),
    .flush(flush), .flush_addr(flush_addr), .tail_err(tail_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op;
    logic [4:0] off;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         failures = 0;
  logic [2:0] len_tab[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every accepted op must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && op_valid && op_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL op_unexpected: got op 0x%0h, expected no handshake at %0t", op, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("op", {60'd0, op}, {60'd0, mon_e.op});
        check("op_tail_off", {59'd0, op_tail_off}, {59'd0, mon_e.off});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] o, input logic [4:0] off);
    exp_t e;
    e.op  = o;
    e.off = off;
    exp_q.push_back(e);
  endtask

  task automatic clear_lens();
    for (int i = 0; i < 16; i++) len_tab[i] = 3'd0;
  endtask

  task automatic do_fetch(input logic [ADDR_W-1:0] addr, input logic [63:0] data);
    int n = 0;
    while (!fetch_req && n < 20) begin
      step();
      n++;
    end
    check("fetch_req_seen", {63'd0, fetch_req}, 64'd1);
    check("fetch_addr", {48'd0, fetch_addr}, {48'd0, addr});
    fetch_ack  = 1'b1;
    fetch_data = data;
    step();
    fetch_ack  = 1'b0;
    fetch_data = '0;
    check("op_valid_latency", {63'd0, op_valid}, 64'd1);
  endtask

  task automatic run_ops(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      op_len   = len_tab[start + i];
      op_ready = 1'b1;
      check("op_valid_run", {63'd0, op_valid}, 64'd1);
      step();
    end
    op_ready = 1'b0;
    op_len   = '0;
  endtask

  initial begin
    clear_lens();
    // Reset state
    step();
    step();
    check("rst_fetch_req", {63'd0, fetch_req}, 64'd0);
    check("rst_fetch_addr", {48'd0, fetch_addr}, 64'd0);
    check("rst_op_valid", {63'd0, op_valid}, 64'd0);
    check("rst_tail_err", {63'd0, tail_err}, 64'd0);
    check("rst_ir", ir, 64'd0);
    reset = 1'b0;
    step();
    check("req_after_reset", {63'd0, fetch_req}, 64'd1);

    // Full word, no tails: ops 1..F,0
    for (int i = 0; i < 16; i++) push_exp(4'(i + 1), 5'd0);
    do_fetch(16'd0, W1);
    run_ops(0, 16);
    check("refetch_req", {63'd0, fetch_req}, 64'd1);
    check("refetch_addr", {48'd0, fetch_addr}, 64'd1);
    check("refetch_op_valid", {63'd0, op_valid}, 64'd0);

    // Tail of 3 on the first op: 13 ops, offsets 0,3,3,...
    len_tab[0] = 3'd3;
    for (int i = 0; i < 13; i++) push_exp(4'(i + 1), (i == 0) ? 5'd0 : 5'd3);
    do_fetch(16'd1, W1);
    run_ops(0, 13);
    check("tail3_req", {63'd0, fetch_req}, 64'd1);
    check("tail3_addr", {48'd0, fetch_addr}, 64'd2);
    check("tail3_no_err", {63'd0, tail_err}, 64'd0);

    // Exact fit: op_len=5 at p=10 -> s=16
    clear_lens();
    len_tab[10] = 3'd5;
    for (int i = 0; i < 11; i++) push_exp(4'(i + 1), 5'd0);
    do_fetch(16'd2, W1);
    run_ops(0, 11);
    check("exact_no_err", {63'd0, tail_err}, 64'd0);
    check("exact_req", {63'd0, fetch_req}, 64'd1);
    check("exact_addr", {48'd0, fetch_addr}, 64'd3);

    // Overlap: op_len=6 at p=10 -> s=17, tail_err pulse
    len_tab[10] = 3'd6;
    for (int i = 0; i < 11; i++) push_exp(4'(i + 1), 5'd0);
    do_fetch(16'd3, W1);
    run_ops(0, 11);
    check("overlap_err", {63'd0, tail_err}, 64'd1);
    check("overlap_req", {63'd0, fetch_req}, 64'd1);
    check("overlap_op_valid", {63'd0, op_valid}, 64'd0);
    step();
    check("overlap_err_pulse", {63'd0, tail_err}, 64'd0);

    // Stall mid-word for 5 cycles, then resume on the same slot
    clear_lens();
    len_tab[1] = 3'd2;
    for (int i = 0; i < 14; i++) push_exp(4'(15 - i), (i < 2) ? 5'd0 : 5'd2);
    do_fetch(16'd4, W2);
    run_ops(0, 3);
    for (int k = 0; k < 5; k++) begin
      check("stall_op", {60'd0, op}, 64'hC);
      check("stall_tail_off", {59'd0, op_tail_off}, 64'd2);
      check("stall_ir", ir, W2);
      check("stall_op_valid", {63'd0, op_valid}, 64'd1);
      step();
    end
    run_ops(3, 11);
    check("stall_end_addr", {48'd0, fetch_addr}, 64'd5);

    // Flush in ISSUE
    clear_lens();
    push_exp(4'h1, 5'd0);
    push_exp(4'h2, 5'd0);
    do_fetch(16'd5, W1);
    run_ops(0, 2);
    op_ready   = 1'b1;
    flush      = 1'b1;
    flush_addr = 16'h0040;
    #1;
    check("flush_op_valid", {63'd0, op_valid}, 64'd0);
    step();
    flush    = 1'b0;
    op_ready = 1'b0;
    check("flush_req", {63'd0, fetch_req}, 64'd1);
    check("flush_addr", {48'd0, fetch_addr}, 64'h40);
    check("flush_op_valid_after", {63'd0, op_valid}, 64'd0);

    // Flush during an outstanding fetch at address 7
    do_fetch(16'h0040, W1);
    flush      = 1'b1;
    flush_addr = 16'd7;
    step();
    flush = 1'b0;
    check("redir_req", {63'd0, fetch_req}, 64'd1);
    check("redir_addr", {48'd0, fetch_addr}, 64'd7);
    flush      = 1'b1;
    flush_addr = 16'h0100;
    step();
    flush = 1'b0;
    check("discard_hold_req", {63'd0, fetch_req}, 64'd1);
    check("discard_hold_addr", {48'd0, fetch_addr}, 64'd7);
    flush      = 1'b1;
    flush_addr = 16'h0123;
    step();
    flush = 1'b0;
    check("discard_hold2_req", {63'd0, fetch_req}, 64'd1);
    check("discard_hold2_addr", {48'd0, fetch_addr}, 64'd7);
    fetch_ack  = 1'b1;
    fetch_data = W2;
    step();
    fetch_ack  = 1'b0;
    fetch_data = '0;
    check("discard_idle_req", {63'd0, fetch_req}, 64'd0);
    check("discard_op_valid", {63'd0, op_valid}, 64'd0);
    check("discard_new_addr", {48'd0, fetch_addr}, 64'h123);
    step();
    check("discard_rereq", {63'd0, fetch_req}, 64'd1);
    check("discard_rereq_addr", {48'd0, fetch_addr}, 64'h123);
    push_exp(4'h0, 5'd0);
    push_exp(4'hF, 5'd0);
    do_fetch(16'h0123, W3);
    run_ops(0, 2);

    // Reset mid-operation; an ack right after release is ignored
    reset = 1'b1;
    #1;
    check("midrst_op_valid", {63'd0, op_valid}, 64'd0);
    check("midrst_req", {63'd0, fetch_req}, 64'd0);
    check("midrst_ir", ir, 64'd0);
    check("midrst_addr", {48'd0, fetch_addr}, 64'd0);
    step();
    reset      = 1'b0;
    fetch_ack  = 1'b1;
    fetch_data = W1;
    step();
    fetch_ack  = 1'b0;
    fetch_data = '0;
    check("ack_ignored", {63'd0, op_valid}, 64'd0);
    check("post_rst_req", {63'd0, fetch_req}, 64'd1);
    check("post_rst_addr", {48'd0, fetch_addr}, 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
